// File: rtl/inst_fetch_memory_pkg.sv
// Shared definitions for the instruction fetch memory.
//   FAULT_*          : two-bit fault codes carried on resp_fault
//   NOP_WORD_DEFAULT : word returned on a fault and written by the init clear
//   fetch_state_e    : controller state encoding
package inst_fetch_memory_pkg;

   localparam logic [1:0] FAULT_OK       = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE    = 2'b10;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_memory_imem_word_ram.sv
// Single-write-port, single-read-port synchronous word RAM.
// The read register samples the array before the same-edge write lands,
// so a read and write of one index in one cycle returns the old word.
// The array has no reset; only the read register is reset.
//   clk, reset_n  : clock, async active-low reset (read register only)
//   wr_en_i       : write strobe
//   wr_idx_i      : word index written
//   wr_data_i     : word written
//   rd_en_i       : read strobe; rd_data_o holds its value otherwise
//   rd_idx_i      : word index read
//   rd_data_o     : registered read data
module imem_word_ram #(
   parameter int          WORDS     = 32,
   parameter int          IDX_W     = $clog2(WORDS),
   parameter logic [31:0] RST_RDATA = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [31:0]      wr_data_i,
   input  logic             rd_en_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [31:0]      rd_data_o
);

   logic [31:0] mem_q [WORDS];
   logic [31:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= RST_RDATA;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_idx_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_fetch_memory.sv
// Instruction fetch memory: word RAM with a one-entry response buffer,
// address fault checking, a program-load write port and a power-on clear.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | writing NOP_WORD to every word; fetch and program blocked
//   ST_RUN   | fetches served, program writes accepted, init_done high
//
// Ports
//   clk, reset_n          : clock, async active-low reset
//   req_valid/req_ready   : fetch request handshake, req_addr byte address
//   resp_valid/resp_ready : response handshake, resp_instr/resp_fault data
//   flush                 : drop buffered response and same-cycle request
//   prog_valid/prog_ready : program write handshake, prog_addr/prog_data
//   init_done             : clear sequence complete
module inst_fetch_memory
   import inst_fetch_memory_pkg::*;
#(
   parameter int          ADDR_W      = 64,
   parameter int          DEPTH_BYTES = 128,
   parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [ADDR_W-1:0]                req_addr,
   output logic                             resp_valid,
   input  logic                             resp_ready,
   output logic [31:0]                      resp_instr,
   output logic [1:0]                       resp_fault,
   input  logic                             flush,
   input  logic                             prog_valid,
   output logic                             prog_ready,
   input  logic [$clog2(DEPTH_BYTES/4)-1:0] prog_addr,
   input  logic [31:0]                      prog_data,
   output logic                             init_done
);

   localparam int WORDS = DEPTH_BYTES / 4;
   localparam int IDX_W = $clog2(WORDS);

   fetch_state_e     state_q;
   // Extra MSB marks "all words written"; one more edge then enters RUN.
   logic [IDX_W:0]   clr_cnt_q;
   logic             init_done_q;

   logic             resp_valid_q, resp_valid_d;
   logic [1:0]       resp_fault_q, resp_fault_d;
   logic [1:0]       req_fault;
   logic             req_accept;

   logic             ram_wr_en;
   logic [IDX_W-1:0] ram_wr_idx;
   logic [31:0]      ram_wr_data;
   logic             ram_rd_en;
   logic [31:0]      ram_rd_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_CLEAR;
         clr_cnt_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (clr_cnt_q[IDX_W]) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               state_q <= ST_RUN;
            end
            default: begin
               state_q     <= ST_CLEAR;
               clr_cnt_q   <= '0;
               init_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign init_done  = init_done_q;
   assign prog_ready = init_done_q;
   assign req_ready  = init_done_q && !flush && (!resp_valid_q || resp_ready);
   assign req_accept = req_valid && req_ready;

   // Misaligned wins over out of range; range check spans the full address.
   always_comb begin
      req_fault = FAULT_OK;
      if (req_addr[1:0] != 2'b00) begin
         req_fault = FAULT_MISALIGN;
      end else if (req_addr >= ADDR_W'(DEPTH_BYTES)) begin
         req_fault = FAULT_RANGE;
      end
   end

   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_fault_d = resp_fault_q;
      if (flush) begin
         resp_valid_d = 1'b0;
      end else if (req_accept) begin
         resp_valid_d = 1'b1;
         resp_fault_d = req_fault;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_q <= 1'b0;
         resp_fault_q <= FAULT_OK;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
      end
   end

   always_comb begin
      if (state_q == ST_CLEAR) begin
         ram_wr_en   = !clr_cnt_q[IDX_W];
         ram_wr_idx  = clr_cnt_q[IDX_W-1:0];
         ram_wr_data = NOP_WORD;
      end else begin
         ram_wr_en   = prog_valid;
         ram_wr_idx  = prog_addr;
         ram_wr_data = prog_data;
      end
   end

   // RAM read register doubles as the response data buffer: it only moves
   // on an accepted in-range fetch, so stalls and program writes leave it be.
   assign ram_rd_en = req_accept && (req_fault == FAULT_OK);

   imem_word_ram #(
      .WORDS     (WORDS),
      .IDX_W     (IDX_W),
      .RST_RDATA (NOP_WORD)
   ) u_ram (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (ram_wr_en),
      .wr_idx_i  (ram_wr_idx),
      .wr_data_i (ram_wr_data),
      .rd_en_i   (ram_rd_en),
      .rd_idx_i  (req_addr[IDX_W+1:2]),
      .rd_data_o (ram_rd_data)
   );

   assign resp_valid = resp_valid_q;
   assign resp_fault = resp_fault_q;
   assign resp_instr = (resp_fault_q == FAULT_OK) ? ram_rd_data : NOP_WORD;

endmodule

// File: tb/tb_inst_fetch_memory.sv
module tb_inst_fetch_memory;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_addr = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_instr;
   logic [1:0]  resp_fault;
   logic        flush = 1'b0;
   logic        prog_valid = 1'b0;
   logic        prog_ready;
   logic [4:0]  prog_addr = '0;
   logic [31:0] prog_data = '0;
   logic        init_done;

   int checks = 0;
   int errors = 0;

   // bench model
   logic [31:0] exp_mem [32];
   logic [33:0] sb_q [$];
   logic        m_valid;
   logic        m_run;
   int          m_cnt;

   always #5 clk = ~clk;

   inst_fetch_memory #(
      .ADDR_W      (64),
      .DEPTH_BYTES (128),
      .NOP_WORD    (NOP)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_instr (resp_instr),
      .resp_fault (resp_fault),
      .flush      (flush),
      .prog_valid (prog_valid),
      .prog_ready (prog_ready),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .init_done  (init_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] exp_resp(input logic [63:0] a);
      if (a[1:0] != 2'b00)   return {NOP, 2'b01};
      else if (a >= 64'd128) return {NOP, 2'b10};
      else                   return {exp_mem[a[6:2]], 2'b00};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) exp_mem[i] = NOP;
      sb_q.delete();
      m_valid = 1'b0;
      m_run   = 1'b0;
      m_cnt   = 0;
   endtask

   // Asynchronous reset pulse applied between clock edges.
   task automatic do_reset();
      reset_n = 1'b0;
      req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0; prog_valid = 1'b0;
      #1;
      model_reset();
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_instr", resp_instr, NOP);
      chk("rst_resp_fault", resp_fault, 2'b00);
      chk("rst_init_done",  init_done, 1'b0);
      chk("rst_req_ready",  req_ready, 1'b0);
      chk("rst_prog_ready", prog_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One cycle: drive at the falling edge, check before the rising edge,
   // advance the model across the rising edge.
   task automatic step(input logic rv, input logic [63:0] ra, input logic rr,
                       input logic fl, input logic pv, input logic [4:0] pa,
                       input logic [31:0] pd);
      logic exp_rdy;
      req_valid = rv; req_addr = ra; resp_ready = rr; flush = fl;
      prog_valid = pv; prog_addr = pa; prog_data = pd;
      #1;
      exp_rdy = m_run && !fl && (!m_valid || rr);
      chk("req_ready",  req_ready, exp_rdy);
      chk("prog_ready", prog_ready, m_run);
      chk("init_done",  init_done, m_run);
      chk("resp_valid", resp_valid, m_valid);
      if (m_valid && sb_q.size() > 0) begin
         chk("resp_instr", resp_instr, sb_q[0][33:2]);
         chk("resp_fault", resp_fault, sb_q[0][1:0]);
      end
      if (fl) begin
         if (m_valid) void'(sb_q.pop_front());
         m_valid = 1'b0;
      end else begin
         if (m_valid && rr) begin
            void'(sb_q.pop_front());
            m_valid = 1'b0;
         end
         if (exp_rdy && rv) begin
            sb_q.push_back(exp_resp(ra));
            m_valid = 1'b1;
         end
      end
      if (m_run && pv) exp_mem[pa] = pd;
      @(posedge clk);
      if (!m_run) begin
         m_cnt++;
         if (m_cnt == 33) m_run = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic fetch(input logic [63:0] a);
      step(1'b1, a, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic idle();
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic prog(input logic [4:0] pa, input logic [31:0] pd);
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, pa, pd);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset();

      // clear phase: fetch and program attempts must be refused
      for (int i = 0; i < 33; i++)
         step(1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hBAD0_BAD0);

      fetch(64'h0);
      idle();

      // programmed words fetched back-to-back
      prog(5'd0, 32'h0021_1093);
      prog(5'd1, 32'h0140_0113);
      fetch(64'h0);
      fetch(64'h4);
      fetch(64'h14);
      idle();

      // faults and range boundaries
      fetch(64'h6);
      fetch(64'h80);
      fetch(64'hFFFF_FFFF_FFFF_FFFE);
      fetch(64'h7C);
      fetch(64'h7D);
      fetch(64'h1_0000_0000);
      idle();

      // back-pressure: five stalled cycles, then release
      fetch(64'h4);
      for (int i = 0; i < 5; i++)
         step(1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1111_2222);
      step(1'b1, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      fetch(64'h4);
      idle();

      // flush with a buffered response and a pending request
      fetch(64'h0);
      step(1'b1, 64'h4, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      idle();
      idle();

      // read-before-write on the same word
      step(1'b1, 64'h8, 1'b1, 1'b0, 1'b1, 5'd2, 32'hDEAD_BEEF);
      fetch(64'h8);
      idle();

      // reset mid-run restarts the clear
      do_reset();
      for (int i = 0; i < 33; i++) idle();
      fetch(64'h8);
      fetch(64'h0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
